bti_sram_slv: RTL and testbench

BTI_SRAM_SLV -- requirements
Module: bti_sram_slv

---
 rtl/bti_sram_slv.sv | 110 +++++++++++
 tb/tb_bti_sram_slv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bti_sram_slv.sv
// BTI slave backed by a single-port SRAM: fixed 1-cycle response latency,
// byte-strobed writes, and an error response for out-of-window or misaligned accesses.
package bti_pkg;
  typedef enum logic {
    BTI_CMD_READ  = 1'b0,
    BTI_CMD_WRITE = 1'b1
  } bti_cmd_t;
endpackage

`ifndef BTI_TIDW
`define BTI_TIDW 8
`endif

module bti_sram_slv
  import bti_pkg::*;
#(
  parameter int unsigned       BTI_AW    = 32,
  parameter int unsigned       BTI_DW    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [BTI_AW-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [`BTI_TIDW-1:0]  req_tid,
  input  bti_cmd_t              req_cmd,
  input  logic [BTI_AW-1:0]     req_addr,
  input  logic [BTI_DW-1:0]     req_data,
  input  logic [BTI_DW/8-1:0]   req_strobe,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [`BTI_TIDW-1:0]  rsp_tid,
  output logic [BTI_DW-1:0]     rsp_data,
  output logic                  rsp_err
);

  localparam int unsigned NB  = BTI_DW / 8;
  localparam int unsigned BSH = $clog2(NB);
  localparam int unsigned IW  = $clog2(DEPTH);
  // Window size carries one extra bit so a window covering the whole address space still compares.
  localparam logic [BTI_AW:0] WIN = (BTI_AW + 1)'(DEPTH * NB);

  logic [BTI_DW-1:0]    mem_q [DEPTH];

  logic                 rsp_vld_q, rsp_vld_d;
  logic [`BTI_TIDW-1:0] rsp_tid_q, rsp_tid_d;
  logic [BTI_DW-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [BTI_AW-1:0]    offset;
  logic                 in_range, misaligned, acc_ok, fire, we;
  logic [IW-1:0]        widx;

  assign req_rdy = !rsp_vld_q || rsp_rdy;
  assign fire    = req_vld && req_rdy;

  always_comb begin
    offset     = req_addr - BASE_ADDR;
    in_range   = (req_addr >= BASE_ADDR) && ({1'b0, offset} < WIN);
    misaligned = (req_addr & BTI_AW'(NB - 1)) != '0;
    acc_ok     = in_range && !misaligned;
    widx       = IW'(offset >> BSH);
    we         = fire && acc_ok && (req_cmd == BTI_CMD_WRITE) && rst_n;
  end

  // Contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (req_strobe[b]) mem_q[widx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_tid_d  = rsp_tid_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (fire) begin
      rsp_vld_d  = 1'b1;
      rsp_tid_d  = req_tid;
      rsp_err_d  = !acc_ok;
      rsp_data_d = (acc_ok && req_cmd == BTI_CMD_READ) ? mem_q[widx] : '0;
    end else if (rsp_rdy) begin
      rsp_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q  <= 1'b0;
      rsp_tid_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_tid_q  <= rsp_tid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_vld  = rsp_vld_q;
  assign rsp_tid  = rsp_tid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_bti_sram_slv.sv
// Directed bench for bti_sram_slv: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
`ifndef BTI_TIDW
`define BTI_TIDW 8
`endif

module tb_bti_sram_slv;
  import bti_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_vld = 1'b0;
  logic                 req_rdy;
  logic [`BTI_TIDW-1:0] req_tid = '0;
  bti_cmd_t             req_cmd = BTI_CMD_READ;
  logic [31:0]          req_addr = '0;
  logic [31:0]          req_data = '0;
  logic [3:0]           req_strobe = '0;
  logic                 rsp_vld;
  logic                 rsp_rdy = 1'b1;
  logic [`BTI_TIDW-1:0] rsp_tid;
  logic [31:0]          rsp_data;
  logic                 rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  bti_sram_slv #(.BTI_AW(32), .BTI_DW(32), .DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_tid(req_tid), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_strobe(req_strobe),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_tid(rsp_tid),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: word array, written flags, and the single outstanding response.
  logic [31:0]          mm [1024];
  bit                   mw [1024];
  bit                   m_vld = 0;
  logic [`BTI_TIDW-1:0] m_tid = '0;
  logic [31:0]          m_data = '0;
  bit                   m_err = 0;
  bit                   m_known = 1;

  always @(negedge rst_n) begin
    m_vld = 0; m_tid = '0; m_data = '0; m_err = 0; m_known = 1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      longint a;
      int     w;
      bit     ok;
      a  = longint'(req_addr);
      ok = (a >= 0) && (a < 4096) && (a % 4 == 0);
      w  = int'(a / 4);
      if (req_vld && (!m_vld || rsp_rdy)) begin
        m_vld = 1; m_tid = req_tid; m_err = !ok; m_data = 32'h0; m_known = 1;
        if (ok && req_cmd == BTI_CMD_WRITE) begin
          for (int b = 0; b < 4; b++)
            if (req_strobe[b]) begin
              mm[w][8*b +: 8] = req_data[8*b +: 8];
              mw[w] = 1;
            end
        end else if (ok) begin
          m_data  = mm[w];
          m_known = mw[w];
        end
      end else if (rsp_rdy) begin
        m_vld = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("rsp_vld", {63'b0, rsp_vld}, {63'b0, m_vld});
    chk("req_rdy", {63'b0, req_rdy}, {63'b0, (!m_vld || rsp_rdy)});
    if (m_vld) begin
      chk("rsp_tid", 64'(rsp_tid), 64'(m_tid));
      chk("rsp_err", {63'b0, rsp_err}, {63'b0, m_err});
      if (m_known) chk("rsp_data", 64'(rsp_data), 64'(m_data));
    end
  end

  task automatic drive(input logic v, input bti_cmd_t c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [`BTI_TIDW-1:0] t, input logic r);
    req_vld = v; req_cmd = c; req_addr = a; req_data = d; req_strobe = s;
    req_tid = t; rsp_rdy = r;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, BTI_CMD_READ, 32'h0, 32'h0, 4'h0, '0, 1'b1);
  endtask

  task automatic lit(input string nm, input logic [`BTI_TIDW-1:0] t,
                     input logic e, input logic [31:0] d);
    chk({nm, ".vld"}, {63'b0, rsp_vld}, 64'd1);
    chk({nm, ".tid"}, 64'(rsp_tid), 64'(t));
    chk({nm, ".err"}, {63'b0, rsp_err}, {63'b0, e});
    chk({nm, ".data"}, 64'(rsp_data), 64'(d));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst.vld", {63'b0, rsp_vld}, 64'd0);
    chk("rst.tid", 64'(rsp_tid), 64'd0);
    chk("rst.data", 64'(rsp_data), 64'd0);
    chk("rst.err", {63'b0, rsp_err}, 64'd0);
    chk("rst.rdy", {63'b0, req_rdy}, 64'd1);
    rst_n = 1'b1;
    idle();

    // Full write then read-back, including read directly after write.
    drive(1'b1, BTI_CMD_WRITE, 32'h10, 32'hDEADBEEF, 4'hF, 8'd3, 1'b1);
    lit("wr10", 8'd3, 1'b0, 32'h0);
    drive(1'b1, BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 8'd4, 1'b1);
    lit("rd10", 8'd4, 1'b0, 32'hDEADBEEF);

    // Byte strobes and zero-strobe no-op write.
    drive(1'b1, BTI_CMD_WRITE, 32'h20, 32'h11223344, 4'hF, 8'd5, 1'b1);
    drive(1'b1, BTI_CMD_WRITE, 32'h20, 32'h0000AA00, 4'h2, 8'd6, 1'b1);
    drive(1'b1, BTI_CMD_READ, 32'h20, 32'h0, 4'h0, 8'd7, 1'b1);
    lit("strb", 8'd7, 1'b0, 32'h1122AA44);
    drive(1'b1, BTI_CMD_WRITE, 32'h20, 32'hFFFFFFFF, 4'h0, 8'd8, 1'b1);
    lit("nowr", 8'd8, 1'b0, 32'h0);
    drive(1'b1, BTI_CMD_READ, 32'h20, 32'h0, 4'h0, 8'd9, 1'b1);
    lit("nowr_rd", 8'd9, 1'b0, 32'h1122AA44);

    // Decode/alignment errors and window edges.
    drive(1'b1, BTI_CMD_READ, 32'h1000, 32'h0, 4'h0, 8'd10, 1'b1);
    lit("oor", 8'd10, 1'b1, 32'h0);
    drive(1'b1, BTI_CMD_WRITE, 32'h22, 32'h0, 4'hF, 8'd11, 1'b1);
    lit("mis_wr", 8'd11, 1'b1, 32'h0);
    drive(1'b1, BTI_CMD_READ, 32'h21, 32'h0, 4'h0, 8'd12, 1'b1);
    lit("mis_rd", 8'd12, 1'b1, 32'h0);
    drive(1'b1, BTI_CMD_READ, 32'h20, 32'h0, 4'h0, 8'd13, 1'b1);
    lit("unchg", 8'd13, 1'b0, 32'h1122AA44);
    drive(1'b1, BTI_CMD_WRITE, 32'hFFC, 32'hCAFEF00D, 4'hF, 8'd14, 1'b1);
    drive(1'b1, BTI_CMD_WRITE, 32'h1000, 32'h0, 4'hF, 8'd15, 1'b1);
    lit("oor_wr", 8'd15, 1'b1, 32'h0);
    drive(1'b1, BTI_CMD_READ, 32'hFFC, 32'h0, 4'h0, 8'd16, 1'b1);
    lit("lastw", 8'd16, 1'b0, 32'hCAFEF00D);
    drive(1'b1, BTI_CMD_READ, 32'h0, 32'h0, 4'h0, 8'd17, 1'b1);
    chk("wrap.err", {63'b0, rsp_err}, 64'd0);

    // Back-to-back: one response per cycle, tids in order.
    for (int i = 0; i < 8; i++)
      drive(1'b1, BTI_CMD_WRITE, 32'h100 + 32'(4*i), 32'hA5000000 | 32'(i), 4'hF, 8'(i), 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, BTI_CMD_READ, 32'h100 + 32'(4*i), 32'h0, 4'h0, 8'(20 + i), 1'b1);
      lit("b2b", 8'(20 + i), 1'b0, 32'hA5000000 | 32'(i));
    end
    idle();
    chk("drain.vld", {63'b0, rsp_vld}, 64'd0);

    // Backpressure: response held, no new fire while stalled.
    drive(1'b1, BTI_CMD_READ, 32'h104, 32'h0, 4'h0, 8'd30, 1'b0);
    lit("stall0", 8'd30, 1'b0, 32'hA5000001);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BTI_CMD_READ, 32'h108, 32'h0, 4'h0, 8'd31, 1'b0);
      chk("stall.rdy", {63'b0, req_rdy}, 64'd0);
      lit("stall", 8'd30, 1'b0, 32'hA5000001);
    end
    drive(1'b1, BTI_CMD_READ, 32'h108, 32'h0, 4'h0, 8'd31, 1'b1);
    lit("resume1", 8'd31, 1'b0, 32'hA5000002);
    drive(1'b1, BTI_CMD_READ, 32'h10C, 32'h0, 4'h0, 8'd32, 1'b1);
    lit("resume2", 8'd32, 1'b0, 32'hA5000003);
    idle();

    // Reset while a response is pending; write attempted during reset must be dropped.
    drive(1'b1, BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 8'd40, 1'b0);
    lit("pend", 8'd40, 1'b0, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.vld", {63'b0, rsp_vld}, 64'd0);
    chk("arst.tid", 64'(rsp_tid), 64'd0);
    chk("arst.data", 64'(rsp_data), 64'd0);
    req_vld = 1'b1; req_cmd = BTI_CMD_WRITE; req_addr = 32'h20;
    req_data = 32'h0; req_strobe = 4'hF; rsp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    req_vld = 1'b0;
    rst_n = 1'b1;
    idle();
    chk("post.vld", {63'b0, rsp_vld}, 64'd0);
    chk("post.rdy", {63'b0, req_rdy}, 64'd1);
    drive(1'b1, BTI_CMD_READ, 32'h20, 32'h0, 4'h0, 8'd41, 1'b1);
    lit("post.rd", 8'd41, 1'b0, 32'h1122AA44);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
